dt_pack: RTL and testbench

Packs an 8-bit-per-pixel 128x128 result map (as written by the distance-transform engine into the res RAM) back into the 1-bit-per-pixel, 16-pixel-per-word sti image format. This is the writer side of the sti interface and the reader side of the res interface. Pixels are thresholded and packed MSB-first. The block sits beside the distance-transform engine on the same two memories and is used for round-trip checking and for regenerating binary masks from distance maps.

---
 rtl/dt_pack_pkg.sv | 9 +
 rtl/dt_pack_shift.sv | 35 +++
 rtl/dt_pack.sv | 94 +++++++++
 tb/tb_dt_pack.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/dt_pack_pkg.sv
// dt_pack_pkg: image geometry, FSM state encoding and default threshold shared by dt_pack and dt_pack_shift
package dt_pack_pkg;
    localparam int IMG_DIM      = 128;
    localparam int FRAME_PIXELS = IMG_DIM * IMG_DIM;
    localparam int PIX_PER_WORD = 16;
    localparam int FRAME_WORDS  = FRAME_PIXELS / PIX_PER_WORD;
    localparam logic [7:0] THRESH_DEF = 8'd1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/dt_pack_shift.sv
// dt_pack_shift: MSB-first 16-pixel packer; emits a completed word with a one-cycle write flag
// Ports: clk, reset (async, active-low), cap_v_i (captured pixel valid), bit_i (thresholded pixel),
//        last_i (captured pixel is the last of its word), wr_o (word complete strobe), word_o (packed word)
module dt_pack_shift
    import dt_pack_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cap_v_i,
    input  logic                    bit_i,
    input  logic                    last_i,
    output logic                    wr_o,
    output logic [PIX_PER_WORD-1:0] word_o
);
    logic [PIX_PER_WORD-1:0] sr_q;
    logic [PIX_PER_WORD-1:0] sr_d;

    assign sr_d = {sr_q[PIX_PER_WORD-2:0], bit_i};

    // The shift register restarts at zero after each completed word so a
    // new word never carries bits from the previous one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q   <= '0;
            wr_o   <= 1'b0;
            word_o <= '0;
        end else begin
            wr_o <= cap_v_i && last_i;
            if (cap_v_i) begin
                sr_q <= last_i ? '0 : sr_d;
                if (last_i) word_o <= sr_d;
            end
        end
    end
endmodule

// File: rtl/dt_pack.sv
// dt_pack: reads an 8-bit 128x128 res map, thresholds each pixel and writes 1-bit packed sti words
// Ports: clk, reset (async, active-low), start (frame request), busy, done (level),
//        res_rd/res_addr/res_di (res RAM read, 1-cycle latency),
//        sti_wr/sti_addr/sti_do (sti word write), fg_count (number of 1-pixels, valid while done)
module dt_pack
    import dt_pack_pkg::*;
#(
    parameter logic [7:0] THRESH     = THRESH_DEF,
    parameter int         IMG_PIXELS = FRAME_PIXELS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        res_rd,
    output logic [13:0] res_addr,
    input  logic [7:0]  res_di,
    output logic        sti_wr,
    output logic [9:0]  sti_addr,
    output logic [15:0] sti_do,
    output logic [14:0] fg_count
);
    localparam logic [13:0] LAST_ADDR = 14'(IMG_PIXELS - 1);

    state_e      state_q;
    logic        busy_q, done_q, rd_q, cap_v_q;
    logic [13:0] addr_q, cap_addr_q;
    logic [9:0]  sti_addr_q;
    logic [14:0] fg_q;
    logic        pix, last_px;

    assign pix     = res_di >= THRESH;
    assign last_px = cap_addr_q[3:0] == 4'hF;

    dt_pack_shift u_shift (
        .clk     (clk),
        .reset   (reset),
        .cap_v_i (cap_v_q),
        .bit_i   (pix),
        .last_i  (last_px),
        .wr_o    (sti_wr),
        .word_o  (sti_do)
    );

    // res_addr_q doubles as the issue counter; cap_* is the same stream
    // delayed one cycle to line up with the RAM read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            cap_v_q    <= 1'b0;
            cap_addr_q <= '0;
            sti_addr_q <= '0;
            fg_q       <= '0;
        end else begin
            cap_v_q    <= rd_q;
            cap_addr_q <= addr_q;
            if (cap_v_q && pix) fg_q <= fg_q + 15'd1;
            if (cap_v_q && last_px) sti_addr_q <= cap_addr_q[13:4];
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_q <= RUN;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                    rd_q    <= 1'b1;
                    addr_q  <= '0;
                    fg_q    <= '0;
                end
                RUN: if (addr_q == LAST_ADDR) begin
                    state_q <= DRAIN;
                    rd_q    <= 1'b0;
                end else begin
                    addr_q <= addr_q + 14'd1;
                end
                DRAIN: if (cap_v_q && cap_addr_q == LAST_ADDR) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign res_rd   = rd_q;
    assign res_addr = addr_q;
    assign sti_addr = sti_addr_q;
    assign fg_count = fg_q;
endmodule

// File: tb/tb_dt_pack.sv
// tb_dt_pack: directed frames against two dt_pack instances (THRESH=1 and THRESH=3) sharing one res image
module tb_dt_pack;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  busy, done, res_rd, sti_wr;
    logic [13:0] res_addr [2];
    logic [7:0]  res_di [2];
    logic [9:0]  sti_addr [2];
    logic [15:0] sti_do [2];
    logic [14:0] fg_count [2];
    logic [7:0]  mem [16384];

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dt_pack #(.THRESH(8'd1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .busy(busy[0]), .done(done[0]),
        .res_rd(res_rd[0]), .res_addr(res_addr[0]), .res_di(res_di[0]),
        .sti_wr(sti_wr[0]), .sti_addr(sti_addr[0]), .sti_do(sti_do[0]), .fg_count(fg_count[0])
    );

    dt_pack #(.THRESH(8'd3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .busy(busy[1]), .done(done[1]),
        .res_rd(res_rd[1]), .res_addr(res_addr[1]), .res_di(res_di[1]),
        .sti_wr(sti_wr[1]), .sti_addr(sti_addr[1]), .sti_do(sti_do[1]), .fg_count(fg_count[1])
    );

    always @(posedge clk) begin
        if (res_rd[0]) res_di[0] <= mem[res_addr[0]];
        if (res_rd[1]) res_di[1] <= mem[res_addr[1]];
    end

    int          cyc = 0;
    int          wr_cnt [2], ord_err [2], dbl_err [2];
    int          t_busy [2], t_first [2], t_done [2];
    logic [15:0] words [2][1024];
    logic [1:0]  prev_busy = '0, prev_wr = '0, prev_done = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (busy[i] && !prev_busy[i]) begin
                wr_cnt[i]  <= 0;
                ord_err[i] <= 0;
                dbl_err[i] <= 0;
                t_busy[i]  <= cyc;
                t_first[i] <= 0;
            end else if (sti_wr[i]) begin
                wr_cnt[i] <= wr_cnt[i] + 1;
                if (sti_addr[i] != 10'(wr_cnt[i])) ord_err[i] <= ord_err[i] + 1;
                if (prev_wr[i]) dbl_err[i] <= dbl_err[i] + 1;
                if (wr_cnt[i] == 0) t_first[i] <= cyc;
                words[i][sti_addr[i]] <= sti_do[i];
            end
            if (done[i] && !prev_done[i]) t_done[i] <= cyc;
        end
        prev_busy <= busy;
        prev_wr   <= sti_wr;
        prev_done <= done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int p);
        for (int a = 0; a < 16384; a++)
            mem[a] = p == 0 ? 8'h00 : p == 1 ? 8'hFF : p == 2 ? (a == 17 ? 8'd5 : 8'd0) : 8'(a % 4);
    endtask

    // Expected words/fg per pattern, hand-derived for THRESH=1 (index 0) and THRESH=3 (index 1).
    task automatic run_frame(input int p, input bit mid_start);
        logic [15:0] base [2];
        logic [15:0] w1 [2];
        logic [31:0] fg [2];
        int n = 0;
        case (p)
            0: begin base = '{16'h0000, 16'h0000}; w1 = '{16'h0000, 16'h0000}; fg = '{0, 0}; end
            1: begin base = '{16'hFFFF, 16'hFFFF}; w1 = '{16'hFFFF, 16'hFFFF}; fg = '{16384, 16384}; end
            2: begin base = '{16'h0000, 16'h0000}; w1 = '{16'h4000, 16'h4000}; fg = '{1, 1}; end
            default: begin base = '{16'h7777, 16'h1111}; w1 = '{16'h7777, 16'h1111}; fg = '{12288, 4096}; end
        endcase
        fill(p);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check($sformatf("p%0d_busy1", p), {30'd0, busy}, 32'd3);
        check($sformatf("p%0d_done_clr", p), {30'd0, done}, 32'd0);
        check($sformatf("p%0d_rd1", p), {30'd0, res_rd}, 32'd3);
        check($sformatf("p%0d_addr0", p), {18'd0, res_addr[0]}, 32'd0);
        while (done != 2'b11 && n < 20000) begin
            start = mid_start && n == 3000;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check($sformatf("p%0d_timeout", p), {31'd0, n >= 20000}, 32'd0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int bad = 0;
            for (int w = 0; w < 1024; w++)
                if (words[i][w] !== ((p == 2 && w == 1) ? w1[i] : base[i])) bad++;
            check($sformatf("p%0d_i%0d_writes", p, i), wr_cnt[i], 1024);
            check($sformatf("p%0d_i%0d_order", p, i), ord_err[i], 0);
            check($sformatf("p%0d_i%0d_dbl", p, i), dbl_err[i], 0);
            check($sformatf("p%0d_i%0d_badwords", p, i), bad, 0);
            check($sformatf("p%0d_i%0d_word1", p, i), {16'd0, words[i][1]}, {16'd0, w1[i]});
            check($sformatf("p%0d_i%0d_fg", p, i), {17'd0, fg_count[i]}, fg[i]);
            check($sformatf("p%0d_i%0d_first_wr", p, i), t_first[i] - t_busy[i] + 1, 18);
            check($sformatf("p%0d_i%0d_done_cyc", p, i), t_done[i] - t_busy[i] + 1, 16386);
            check($sformatf("p%0d_i%0d_idle", p, i), {30'd0, busy[i], done[i]}, 32'd1);
        end
    endtask

    initial begin
        int w;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {24'd0, busy, done, res_rd, sti_wr}, 32'd0);
        check("rst_addr", {8'd0, sti_addr[0], res_addr[0]}, 32'd0);
        check("rst_data", {sti_do[0], 1'b0, fg_count[0]}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        fill(0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4998) @(negedge clk);
        check("mid_busy", {30'd0, busy}, 32'd3);
        reset = 1'b0;
        #1;
        check("abort_ctrl", {24'd0, busy, done, res_rd, sti_wr}, 32'd0);
        check("abort_addr", {8'd0, sti_addr[0], res_addr[0]}, 32'd0);
        check("abort_data", {sti_do[0], 1'b0, fg_count[0]}, 32'd0);
        check("abort_data1", {sti_do[1], 1'b0, fg_count[1]}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        w = wr_cnt[0];
        repeat (40) @(negedge clk);
        check("no_wr_after_rst", wr_cnt[0], w);
        check("idle_after_rst", {30'd0, busy}, 32'd0);
        run_frame(0, 1'b0);
        run_frame(1, 1'b1);
        run_frame(2, 1'b0);
        run_frame(3, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
